ccr_unit: RTL
=============

CCR_UNIT -- requirements
Module: ccr_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: flag_we  input  1  ALU flag result valid this cycle.
REQ-004 SHALL have port: flag_mask  input  4  per-flag write enable, bit order [V C N Z].
REQ-005 SHALL have port: flags_in  input  4  ALU flag values [V C N Z]; unmasked bits may be X.
REQ-006 SHALL have port: stall  input  1  pipeline hold; freezes all state.
REQ-007 SHALL have port: int_save  input  1  interrupt entry; push CCR to shadow stack.
REQ-008 SHALL have port: rti_restore  input  1  return from interrupt; pop shadow stack into CCR.
REQ-009 SHALL have port: jcond_chk  input  1  conditional jump under evaluation.
REQ-010 SHALL have port: jcond_sel  input  2  tested flag: 00 Z, 01 N, 10 C, 11 V.
REQ-011 SHALL have port: ccr  output  4  registered flags [V C N Z].
REQ-012 SHALL have port: carry  output  1  ccr[2], ALU carry-in.
REQ-013 SHALL have port: take_branch  output  1  combinational jump-taken decision.
REQ-014 SHALL have port: shadow_depth  output  2  shadow entries held (0..2).
REQ-015 SHALL have port: shadow_err  output  1  sticky overflow/underflow flag.

Function
REQ-016 SHALL compute merged = (flags_in & flag_mask) | (ccr & ~flag_mask) when flag_we=1, else merged = ccr; X on unmasked flags_in bits never reaches merged.
REQ-017 SHALL drive take_branch = jcond_chk & ~stall & merged[sel bit] (bypass: a same-cycle ALU write to the tested flag is seen, zero added latency).
REQ-018 SHALL, when take_branch=1, clear the tested flag in next ccr (consume-on-jump), unless flag_we=1 with the same bit masked, in which case the ALU value wins.
REQ-019 SHALL, when no event is active, load ccr <= merged (with consume applied) each non-stalled cycle; latency flag_we -> ccr = 1 cycle.
REQ-020 SHALL, when stall=1, hold ccr, shadow stack, shadow_depth and shadow_err unchanged and ignore all other inputs.
REQ-021 SHALL implement a 2-entry LIFO shadow stack; states EMPTY (depth 0), ONE (1), FULL (2).
REQ-022 SHALL, on int_save in EMPTY/ONE, push merged (post-ALU, post-consume value) and increment depth; ccr <= merged.
REQ-023 SHALL, on int_save in FULL, keep stack and depth unchanged, set shadow_err, ccr <= merged.
REQ-024 SHALL, on rti_restore in ONE/FULL, load ccr <= top entry, decrement depth; same-cycle flag_we and consume are discarded.
REQ-025 SHALL, on rti_restore in EMPTY, hold ccr, set shadow_err, leave depth 0.
REQ-026 SHALL, when int_save and rti_restore are both 1, perform only rti_restore (priority rst > stall > rti_restore > int_save > flag_we/consume).
REQ-027 SHALL keep shadow_err set until rst.

Reset
REQ-028 SHALL, on rst=1 at a rising edge, set ccr=4'b0000, shadow_depth=0, shadow_err=0, clear both shadow entries, regardless of stall or any other input, including mid-interrupt.
REQ-029 SHALL force take_branch=0 while rst=1.

Verification
REQ-030 SHALL cover: ccr=0000; flag_we=1, mask=0011, flags_in=4'bxx10 -> next ccr=0010, no X on ccr.
REQ-031 SHALL cover: ccr=0000; same cycle flag_we=1, mask=0001, flags_in=0001, jcond_chk=1, sel=00 -> take_branch=1; next ccr Z=1 (ALU wins over consume).
REQ-032 SHALL cover: ccr=0001, jcond_chk=1, sel=00, flag_we=0 -> take_branch=1, next ccr=0000.
REQ-033 SHALL cover: ccr=0101; int_save -> depth 1; flag_we mask=1111 flags_in=1010 -> ccr=1010; rti_restore -> ccr=0101, depth 0.
REQ-034 SHALL cover: three int_save pulses -> depth 2, shadow_err=1; three rti_restore pulses -> depth 0, ccr holds on third, shadow_err stays 1.
REQ-035 SHALL cover: stall=1 with flag_we, int_save, jcond_chk active -> ccr/depth unchanged, take_branch=0; rst during stall -> all outputs zero next cycle.

Source files
------------

// File: rtl/ccr_unit.sv
// ccr_unit -- condition-code register with jump bypass and interrupt shadow stack.
//
// Holds the four ALU flags [V C N Z]. Each cycle the ALU can overwrite any subset
// of them (flag_we/flag_mask/flags_in). A conditional jump tests one flag with
// the same-cycle ALU result bypassed in, and a taken jump clears that flag. On
// interrupt entry the flags are pushed onto a 2-deep LIFO. On return from the
// interrupt the top entry is popped back into the register.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset, overrides everything
//   flag_we       ALU flag result valid this cycle
//   flag_mask     per-flag write enable [V C N Z]
//   flags_in      ALU flag values [V C N Z] (unmasked bits may be X)
//   stall         pipeline hold, freezes all state
//   int_save      interrupt entry: push flags to shadow stack
//   rti_restore   interrupt return: pop shadow stack into flags
//   jcond_chk     conditional jump under evaluation
//   jcond_sel     tested flag: 00 Z, 01 N, 10 C, 11 V
//   ccr           registered flags [V C N Z]
//   carry         ccr[2], ALU carry-in
//   take_branch   combinational jump-taken decision
//   shadow_depth  number of shadow entries held (0..2)
//   shadow_err    sticky stack overflow/underflow flag
module ccr_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       flag_we,
  input  logic [3:0] flag_mask,
  input  logic [3:0] flags_in,
  input  logic       stall,
  input  logic       int_save,
  input  logic       rti_restore,
  input  logic       jcond_chk,
  input  logic [1:0] jcond_sel,
  output logic [3:0] ccr,
  output logic       carry,
  output logic       take_branch,
  output logic [1:0] shadow_depth,
  output logic       shadow_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } depth_t;

  depth_t     depth_reg;
  logic [3:0] ccr_reg;
  logic       err_reg;

  logic [3:0] merged;
  logic [3:0] ccr_next;
  logic       take;
  logic       push;
  logic [3:0] top;
  logic [3:0] shadow_q [2];

  // ALU merge: masking flags_in before the OR keeps X on unwritten bits out.
  // The consumed flag is only cleared if the ALU is not writing that same bit.
  always_comb begin
    merged   = flag_we ? ((flags_in & flag_mask) | (ccr_reg & ~flag_mask)) : ccr_reg;
    take     = jcond_chk & ~stall & ~rst & merged[jcond_sel];
    ccr_next = merged;
    if (take && !(flag_we && flag_mask[jcond_sel])) begin
      ccr_next[jcond_sel] = 1'b0;
    end
  end

  // A push happens only when no restore has priority and there is room.
  assign push = ~rst & ~stall & ~rti_restore & int_save & (depth_reg != FULL);

  // Entry gi is written when the current depth points at it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_shadow
      localparam logic [1:0] IDX = 2'(gi);
      logic [3:0] entry_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg <= 4'b0000;
        end else if (push && (depth_reg == depth_t'(IDX))) begin
          entry_reg <= ccr_next;
        end
      end
      assign shadow_q[gi] = entry_reg;
    end
  endgenerate

  assign top = (depth_reg == FULL) ? shadow_q[1] : shadow_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_reg <= EMPTY;
      ccr_reg   <= 4'b0000;
      err_reg   <= 1'b0;
    end else if (!stall) begin
      if (rti_restore) begin
        // Restore discards any same-cycle ALU write and jump consume.
        case (depth_reg)
          EMPTY: err_reg <= 1'b1;
          ONE: begin
            ccr_reg   <= top;
            depth_reg <= EMPTY;
          end
          FULL: begin
            ccr_reg   <= top;
            depth_reg <= ONE;
          end
          default: depth_reg <= EMPTY;
        endcase
      end else if (int_save) begin
        ccr_reg <= ccr_next;
        case (depth_reg)
          EMPTY:   depth_reg <= ONE;
          ONE:     depth_reg <= FULL;
          FULL:    err_reg   <= 1'b1;
          default: depth_reg <= EMPTY;
        endcase
      end else begin
        ccr_reg <= ccr_next;
      end
    end
  end

  assign ccr          = ccr_reg;
  assign carry        = ccr_reg[2];
  assign take_branch  = take;
  assign shadow_depth = depth_reg;
  assign shadow_err   = err_reg;

endmodule
